vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter DIV, default 4: clk cycles per pixel (100 MHz -> 25 MHz pixel rate); legal range 2..16.
REQ-002 Parameter H_DISP, default 640: visible pixels per line.
REQ-003 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal porch and sync widths in pixels; H_TOTAL = 800.
REQ-004 Parameter V_DISP, default 480: visible lines per frame.
REQ-005 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical porch and sync widths in lines; V_TOTAL = 525.
REQ-006 Parameter BLINK_FRAMES, default 30: frames per blink half-period.
REQ-007 The ports SHALL be:
- clk  in  1: system clock; one clock; all state on its rising edge.
- rst  in  1: asynchronous, active-low reset.
- pclk_en  out  1: one-clk pixel-advance strobe.
- h_cnt  out  10: pixel column, 0..H_TOTAL-1.
- v_cnt  out  10: line, 0..V_TOTAL-1.
- hsync  out  1: horizontal sync, active-low.
- vsync  out  1: vertical sync, active-low.
- valid  out  1: high when h_cnt < H_DISP and v_cnt < V_DISP.
- frame_tick  out  1: one-clk pulse at each frame wrap.
- blink  out  1: slow square wave for menu cursor and text flashing.

Function
REQ-008 Divider counter SHALL count 0..DIV-1 and wrap; pclk_en SHALL be high exactly in the clk cycle where the divider equals DIV-1, i.e. once every DIV clks.
REQ-009 h_cnt SHALL increment only on clk edges where pclk_en=1; at H_TOTAL-1 it SHALL wrap to 0.
REQ-010 v_cnt SHALL increment only on edges where pclk_en=1 and h_cnt=H_TOTAL-1; at V_TOTAL-1 it SHALL wrap to 0.
REQ-011 Horizontal phase FSM, advanced on pclk_en: H_ACTIVE (h_cnt 0..639) -> H_FRONT (640..655) -> H_SYNC (656..751) -> H_BACK (752..799) -> H_ACTIVE.
REQ-012 Vertical phase FSM, advanced at line end: V_ACTIVE (0..479) -> V_FRONT (480..489) -> V_SYNC (490..491) -> V_BACK (492..524) -> V_ACTIVE.
REQ-013 Each FSM state SHALL always match its counter range; any mismatch SHALL be corrected on the next pclk_en.
REQ-014 hsync, vsync and valid SHALL be registered, updated on the same edge as the counters, and consistent with the current h_cnt and v_cnt, so latency from the counters is 0.
REQ-015 hsync SHALL be 0 only in H_SYNC; vsync SHALL be 0 only in V_SYNC; hsync is independent of v_cnt.
REQ-016 frame_tick SHALL be 1 for exactly the one clk in which the counters hold (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
REQ-017 frame_tick SHALL NOT assert on the (0,0) produced by reset.
REQ-018 Frame counter SHALL count frame_ticks 0..BLINK_FRAMES-1 and wrap; blink SHALL toggle on each wrap, giving a 1 s period at defaults.
REQ-019 Counter widths: 10 bits for h_cnt and v_cnt; ceil(log2(DIV)) for the divider; ceil(log2(BLINK_FRAMES)) for the frame counter. No counter SHALL exceed its terminal value.
REQ-020 h_cnt and v_cnt SHALL be stable between pclk_en strobes, so downstream address generators may treat them as combinational inputs.

Reset
REQ-021 With rst=0, asynchronously: divider=0, h_cnt=0, v_cnt=0, FSMs in H_ACTIVE and V_ACTIVE, hsync=1, vsync=1, valid=1, pclk_en=0, frame_tick=0, frame counter=0, blink=0.
REQ-022 Reset asserted mid-line or mid-frame SHALL abort immediately with no partial sync pulse held.
REQ-023 After release, the first pclk_en SHALL occur DIV clks later, and h_cnt SHALL become 1 on that edge.

Verification
REQ-024 Release reset, count clks -> pclk_en high every 4th clk; h_cnt steps 0,1,2 at clks 4, 8, 12.
REQ-025 Run one full line -> hsync=0 for h_cnt 656..751 only (96 pixels = 384 clks); valid falls at h_cnt=640; h_cnt goes 799 -> 0 and v_cnt increments by 1.
REQ-026 Run one full frame -> vsync=0 for v_cnt 490..491 only; valid=0 for v_cnt >= 480; exactly one frame_tick, after 800*525*4 = 1,680,000 clks.
REQ-027 Run 60 frames -> blink toggles at frames 30 and 60 and is 0 at the end; frame_tick count = 60.
REQ-028 Assert rst at h_cnt=700, v_cnt=491 (both syncs low) -> all outputs take reset values within the same clk; no frame_tick; the next frame restarts at (0,0).
REQ-029 Set DIV=2 and BLINK_FRAMES=2 -> pclk_en every 2nd clk; blink toggles every 2 frames; sync positions unchanged in pixel units.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides clk down to a pixel strobe, walks the
// horizontal/vertical counters and phases, and derives syncs, frame tick and blink.
module vga_timing_gen #(
    parameter int DIV          = 4,
    parameter int H_DISP       = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_DISP       = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pclk_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       valid,
    output logic       frame_tick,
    output logic       blink
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(DIV);
    localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_FRONT_AT = 10'(H_DISP);
    localparam logic [9:0] H_SYNC_AT  = 10'(H_DISP + H_FP);
    localparam logic [9:0] H_BACK_AT  = 10'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0] V_FRONT_AT = 10'(V_DISP);
    localparam logic [9:0] V_SYNC_AT  = 10'(V_DISP + V_FP);
    localparam logic [9:0] V_BACK_AT  = 10'(V_DISP + V_FP + V_SYNC);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {HP_ACTIVE, HP_FRONT, HP_SYNC, HP_BACK} h_phase_t;
    typedef enum logic [1:0] {VP_ACTIVE, VP_FRONT, VP_SYNC, VP_BACK} v_phase_t;

    logic [DIV_W-1:0] div_cnt;
    logic [FRM_W-1:0] frm_cnt;
    logic [9:0]       h_cnt_nxt;
    logic [9:0]       v_cnt_nxt;
    logic             h_last;
    logic             v_last;
    logic             frame_end;
    h_phase_t         h_state, h_state_nxt;
    v_phase_t         v_state, v_state_nxt;
    logic             hsync_nxt, vsync_nxt, valid_nxt;

    // Phase is recomputed from the counter range, so a corrupted state
    // cannot survive past the next pixel strobe.
    function automatic h_phase_t h_phase(input logic [9:0] cnt);
        if (cnt < H_FRONT_AT)     return HP_ACTIVE;
        else if (cnt < H_SYNC_AT) return HP_FRONT;
        else if (cnt < H_BACK_AT) return HP_SYNC;
        else                      return HP_BACK;
    endfunction

    function automatic v_phase_t v_phase(input logic [9:0] cnt);
        if (cnt < V_FRONT_AT)     return VP_ACTIVE;
        else if (cnt < V_SYNC_AT) return VP_FRONT;
        else if (cnt < V_BACK_AT) return VP_SYNC;
        else                      return VP_BACK;
    endfunction

    assign pclk_en   = (div_cnt == DIV_LAST);
    assign h_last    = (h_cnt == H_LAST);
    assign v_last    = (v_cnt == V_LAST);
    assign h_cnt_nxt = h_last ? 10'd0 : h_cnt + 10'd1;
    assign v_cnt_nxt = h_last ? (v_last ? 10'd0 : v_cnt + 10'd1) : v_cnt;
    assign frame_end = pclk_en && h_last && v_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= pclk_en ? '0 : div_cnt + 1'b1;
            if (pclk_en) begin
                h_cnt <= h_cnt_nxt;
                v_cnt <= v_cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_state <= HP_ACTIVE;
            v_state <= VP_ACTIVE;
        end else if (pclk_en) begin
            h_state <= h_state_nxt;
            v_state <= v_state_nxt;
        end
    end

    always_comb begin
        h_state_nxt = h_phase(h_cnt_nxt);
        v_state_nxt = v_phase(v_cnt_nxt);
    end

    // Outputs are decoded from the next phase so the registers line up
    // with the counters on the same edge.
    always_comb begin
        hsync_nxt = (h_state_nxt != HP_SYNC);
        vsync_nxt = (v_state_nxt != VP_SYNC);
        valid_nxt = (h_state_nxt == HP_ACTIVE) && (v_state_nxt == VP_ACTIVE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            valid <= 1'b1;
        end else if (pclk_en) begin
            hsync <= hsync_nxt;
            vsync <= vsync_nxt;
            valid <= valid_nxt;
        end
    end

    // frame_tick marks only the first clk of a wrapped (0,0); blink flips
    // on the same edge as the frame that completes a half-period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_tick <= 1'b0;
            frm_cnt    <= '0;
            blink      <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (frame_end) begin
                if (frm_cnt == FRM_LAST) begin
                    frm_cnt <= '0;
                    blink   <= ~blink;
                end else begin
                    frm_cnt <= frm_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-reset bench for vga_timing_gen on a shrunken raster; expected
// outputs come from a closed-form model of elapsed clks since reset release.
module tb_vga_timing_gen;

    localparam int DIV = 3;
    localparam int HD = 8, HFP = 2, HS = 3, HBP = 2;
    localparam int VD = 5, VFP = 1, VS = 2, VBP = 1;
    localparam int BF = 2;
    localparam int HT = HD + HFP + HS + HBP;
    localparam int VT = VD + VFP + VS + VBP;
    localparam int FRAME_CLKS = HT * VT * DIV;

    typedef struct packed {
        logic       pclk_en;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       valid;
        logic       ft;
        logic       blink;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       pclk_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic       frame_tick;
    logic       blink;

    vga_timing_gen #(
        .DIV(DIV), .H_DISP(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_DISP(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .pclk_en(pclk_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .hsync(hsync), .vsync(vsync), .valid(valid), .frame_tick(frame_tick),
        .blink(blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t exp_q[$];
    obs_t last_exp;
    int   k;
    int   n_checks;
    int   n_fail;
    int   exp_ft_total;
    int   obs_ft_total;

    // Elapsed clk edges since reset release fully determine the raster position.
    function automatic obs_t model(input int kk);
        obs_t m;
        int pix, h, v, frames;
        pix    = kk / DIV;
        h      = pix % HT;
        v      = (pix / HT) % VT;
        frames = pix / (HT * VT);
        m.pclk_en = ((kk % DIV) == DIV - 1);
        m.h       = 10'(h);
        m.v       = 10'(v);
        m.hs      = !(h >= HD + HFP && h < HD + HFP + HS);
        m.vs      = !(v >= VD + VFP && v < VD + VFP + VS);
        m.valid   = (h < HD) && (v < VD);
        m.ft      = ((kk % DIV) == 0) && (pix > 0) && ((pix % (HT * VT)) == 0);
        m.blink   = ((frames / BF) % 2) == 1;
        return m;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // rst_val is the reset level applied shortly after the edge; an edge
    // seen with rst released advances the model by one clk.
    task automatic do_cycle(input logic rst_val);
        @(posedge clk);
        if (rst) k++;
        #1;
        rst = rst_val;
        if (!rst_val) k = 0;
        last_exp = model(k);
        if (last_exp.ft) exp_ft_total++;
        exp_q.push_back(last_exp);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            check("pclk_en",    int'(pclk_en),    int'(e.pclk_en));
            check("h_cnt",      int'(h_cnt),      int'(e.h));
            check("v_cnt",      int'(v_cnt),      int'(e.v));
            check("hsync",      int'(hsync),      int'(e.hs));
            check("vsync",      int'(vsync),      int'(e.vs));
            check("valid",      int'(valid),      int'(e.valid));
            check("frame_tick", int'(frame_tick), int'(e.ft));
            check("blink",      int'(blink),      int'(e.blink));
            if (frame_tick) obs_ft_total++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        n_checks = 0; n_fail = 0; exp_ft_total = 0; obs_ft_total = 0;
        k = 0;
        rst = 1'b0;
        repeat (3) do_cycle(1'b0);

        // Several full frames so blink goes through more than one period.
        repeat (8 * FRAME_CLKS + 5) do_cycle(1'b1);

        // Walk to a point where both syncs are low, then reset mid-pulse.
        guard = 0;
        while (!(last_exp.hs == 1'b0 && last_exp.vs == 1'b0) && guard < 2 * FRAME_CLKS) begin
            do_cycle(1'b1);
            guard++;
        end
        check("reach_both_sync", int'(last_exp.hs == 1'b0 && last_exp.vs == 1'b0), 1);
        do_cycle(1'b1);
        do_cycle(1'b0);
        do_cycle(1'b0);

        for (int seg = 0; seg < 6; seg++) begin
            repeat ($urandom_range(900, 50)) do_cycle(1'b1);
            repeat ($urandom_range(3, 1)) do_cycle(1'b0);
        end

        repeat (2 * FRAME_CLKS + 7) do_cycle(1'b1);

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("frame_tick_total", obs_ft_total, exp_ft_total);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
